// File: rtl/st_align_if.sv
// Store request / data-memory write bundle for st_align.
// slave is the aligner's view; master is the core + memory side.
interface st_align_if #(
  parameter int ADDR_W = 32
);

  logic              st_valid;
  logic              st_ready;
  logic [2:0]        st_funct3;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;

  logic              st_done;
  logic              st_err;
  logic [1:0]        st_err_code;

  modport slave (
    input  st_valid,
    input  st_funct3,
    input  st_addr,
    input  st_data,
    input  mem_ack,
    output st_ready,
    output mem_req,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    output st_done,
    output st_err,
    output st_err_code
  );

  modport master (
    output st_valid,
    output st_funct3,
    output st_addr,
    output st_data,
    output mem_ack,
    input  st_ready,
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    input  st_done,
    input  st_err,
    input  st_err_code
  );

endinterface

// File: rtl/st_align.sv
// Store aligner: narrows rs2 to SB/SH/SW lanes and writes data memory.
// Optional ST_TIMEOUT_EN adds a REQ timeout counter (error code 10).
module st_align #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst_n,
  st_align_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_MIS  = 2'b01;
  localparam logic [1:0] CODE_TO   = 2'b10;
  localparam logic [1:0] CODE_ILL  = 2'b11;

  // The 8-bit timeout counter cannot hold limits outside 2..255
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    localparam int BAD_TIMEOUT = TIMEOUT;
  end

  state_t state;

  logic is_sb;
  logic is_sh;
  logic is_sw;
  logic f3_ok;
  logic mis;

  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;

`ifdef ST_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;
`endif

  assign is_sb = (bus.st_funct3 == 3'b000);
  assign is_sh = (bus.st_funct3 == 3'b001);
  assign is_sw = (bus.st_funct3 == 3'b010);

  assign bus.st_ready = (state == IDLE);

  // Decode width, alignment and lane placement of the incoming store
  always_comb begin
    f3_ok      = 1'b1;
    mis        = 1'b0;
    lane_wdata = bus.st_data;
    lane_be    = 4'b1111;
    unique case (1'b1)
      is_sb: begin
        lane_wdata = {4{bus.st_data[7:0]}};
        lane_be    = 4'b0001 << bus.st_addr[1:0];
      end
      is_sh: begin
        lane_wdata = {2{bus.st_data[15:0]}};
        lane_be    = bus.st_addr[1] ? 4'b1100
                                    : 4'b0011;
        mis        = bus.st_addr[0];
      end
      is_sw: begin
        mis = |bus.st_addr[1:0];
      end
      default: begin
        f3_ok = 1'b0;
      end
    endcase
  end

  // Handshake FSM; every bus output is registered here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_be      <= '0;
      bus.st_done     <= 1'b0;
      bus.st_err      <= 1'b0;
      bus.st_err_code <= CODE_NONE;
`ifdef ST_TIMEOUT_EN
      to_cnt          <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.st_valid) begin
            if (!f3_ok) begin
              state           <= ERR;
              bus.st_err      <= 1'b1;
              bus.st_err_code <= CODE_ILL;
            end else if (mis) begin
              state           <= ERR;
              bus.st_err      <= 1'b1;
              bus.st_err_code <= CODE_MIS;
            end else begin
              state           <= REQ;
              bus.mem_req     <= 1'b1;
              bus.mem_addr    <= {bus.st_addr[ADDR_W-1:2],
                                  2'b00};
              bus.mem_wdata   <= lane_wdata;
              bus.mem_be      <= lane_be;
              bus.st_err_code <= CODE_NONE;
`ifdef ST_TIMEOUT_EN
              to_cnt          <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            state       <= DONE;
            bus.mem_req <= 1'b0;
            bus.st_done <= 1'b1;
`ifdef ST_TIMEOUT_EN
            to_cnt      <= '0;
          end else if (to_cnt == TO_LAST) begin
            state           <= ERR;
            bus.mem_req     <= 1'b0;
            bus.st_err      <= 1'b1;
            bus.st_err_code <= CODE_TO;
            to_cnt          <= '0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
`endif
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.st_done <= 1'b0;
        end
        ERR: begin
          state      <= IDLE;
          bus.st_err <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st_align.sv
// Directed bench for st_align: lanes, errors, latency, reset abort.
// Build with +define+ST_TIMEOUT_EN to also exercise the timeout path.
module tb_st_align;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;

  int n_chk  = 0;
  int n_fail = 0;

  st_align_if #(.ADDR_W(ADDR_W)) bus ();

  st_align #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] d,
    input int          waits,
    input logic [31:0] ea,
    input logic [31:0] ed,
    input logic [3:0]  eb
  );
    bus.st_valid  = 1'b1;
    bus.st_funct3 = f3;
    bus.st_addr   = a;
    bus.st_data   = d;
    step();
    bus.st_valid = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check({tag, " req"},   32'(bus.mem_req), 1);
      check({tag, " addr"},  bus.mem_addr, ea);
      check({tag, " wdata"}, bus.mem_wdata, ed);
      check({tag, " be"},    32'(bus.mem_be), 32'(eb));
      check({tag, " rdy"},   32'(bus.st_ready), 0);
      check({tag, " code"},  32'(bus.st_err_code), 0);
      if (i == waits) bus.mem_ack = 1'b1;
      step();
    end
    bus.mem_ack = 1'b0;
    check({tag, " done"},    32'(bus.st_done), 1);
    check({tag, " req off"}, 32'(bus.mem_req), 0);
    check({tag, " err"},     32'(bus.st_err), 0);
    check({tag, " rdy dn"},  32'(bus.st_ready), 0);
    step();
    check({tag, " done 1c"}, 32'(bus.st_done), 0);
    check({tag, " rdy back"}, 32'(bus.st_ready), 1);
  endtask

  task automatic do_err(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [1:0]  code
  );
    bus.st_valid  = 1'b1;
    bus.st_funct3 = f3;
    bus.st_addr   = a;
    bus.st_data   = 32'hDEAD_BEEF;
    step();
    bus.st_valid = 1'b0;
    check({tag, " req"},  32'(bus.mem_req), 0);
    check({tag, " err"},  32'(bus.st_err), 1);
    check({tag, " code"}, 32'(bus.st_err_code), 32'(code));
    check({tag, " done"}, 32'(bus.st_done), 0);
    step();
    check({tag, " err 1c"}, 32'(bus.st_err), 0);
    check({tag, " hold"},   32'(bus.st_err_code), 32'(code));
    check({tag, " rdy"},    32'(bus.st_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;
    int req_cycles;

    rst_n         = 1'b0;
    bus.st_valid  = 1'b0;
    bus.st_funct3 = 3'b000;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.mem_ack   = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    check("rst req",   32'(bus.mem_req), 0);
    check("rst addr",  bus.mem_addr, 0);
    check("rst wdata", bus.mem_wdata, 0);
    check("rst be",    32'(bus.mem_be), 0);
    check("rst done",  32'(bus.st_done), 0);
    check("rst err",   32'(bus.st_err), 0);
    check("rst code",  32'(bus.st_err_code), 0);
    check("rst rdy",   32'(bus.st_ready), 1);

    do_store("sb", 3'b000, 32'h0000_1003,
             32'hAABB_CC5A, 2,
             32'h0000_1000, 32'h5A5A_5A5A, 4'b1000);

    do_store("sh", 3'b001, 32'h0000_2002,
             32'h1234_BEEF, 0,
             32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);

    do_store("sh lo", 3'b001, 32'h0000_2100,
             32'h0000_7A55, 1,
             32'h0000_2100, 32'h7A55_7A55, 4'b0011);

    do_store("sb0", 3'b000, 32'h0000_2200,
             32'h0000_0011, 0,
             32'h0000_2200, 32'h1111_1111, 4'b0001);

    do_err("sw mis", 3'b010, 32'h0000_3001, 2'b01);
    do_err("f3 ill", 3'b011, 32'h0000_3001, 2'b11);
    do_err("sh mis", 3'b001, 32'h0000_3003, 2'b01);
    do_err("f3 111", 3'b111, 32'h0000_3000, 2'b11);

    do_store("after err", 3'b010, 32'h0000_3004,
             32'h0102_0304, 0,
             32'h0000_3004, 32'h0102_0304, 4'b1111);

`ifdef ST_TIMEOUT_EN
    bus.st_valid  = 1'b1;
    bus.st_funct3 = 3'b010;
    bus.st_addr   = 32'h0000_4000;
    bus.st_data   = 32'h4444_0000;
    step();
    bus.st_valid = 1'b0;
    req_cycles   = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_req) break;
      req_cycles++;
      step();
    end
    check("to req cycles", 32'(req_cycles), TIMEOUT);
    check("to err",  32'(bus.st_err), 1);
    check("to code", 32'(bus.st_err_code), 2);
    check("to done", 32'(bus.st_done), 0);
    bus.mem_ack = 1'b1;
    step();
    check("late ack done", 32'(bus.st_done), 0);
    check("late ack err",  32'(bus.st_err), 0);
    check("late ack req",  32'(bus.mem_req), 0);
    check("late ack rdy",  32'(bus.st_ready), 1);
    step();
    check("late ack2 done", 32'(bus.st_done), 0);
    bus.mem_ack = 1'b0;
`else
    do_store("no to", 3'b010, 32'h0000_4000,
             32'h4444_0000, 20,
             32'h0000_4000, 32'h4444_0000, 4'b1111);
`endif

    bus.st_valid  = 1'b1;
    bus.st_funct3 = 3'b010;
    bus.st_addr   = 32'h0000_5000;
    bus.st_data   = 32'h1122_3344;
    step();
    bus.st_valid = 1'b0;
    check("abort req1", 32'(bus.mem_req), 1);
    step();
    check("abort req2", 32'(bus.mem_req), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort req",   32'(bus.mem_req), 0);
    check("abort rdy",   32'(bus.st_ready), 1);
    check("abort addr",  bus.mem_addr, 0);
    check("abort wdata", bus.mem_wdata, 0);
    check("abort be",    32'(bus.mem_be), 0);
    check("abort done",  32'(bus.st_done), 0);
    check("abort err",   32'(bus.st_err), 0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("idle ack done", 32'(bus.st_done), 0);
    check("idle ack err",  32'(bus.st_err), 0);
    check("idle ack req",  32'(bus.mem_req), 0);

    do_store("post rst", 3'b000, 32'h0000_5001,
             32'h0000_0077, 1,
             32'h0000_5000, 32'h7777_7777, 4'b0010);

    writes        = 0;
    bus.st_valid  = 1'b1;
    bus.st_funct3 = 3'b010;
    bus.st_addr   = 32'h0000_6000;
    bus.st_data   = 32'hCAFE_F00D;
    step();
    check("hold req1", 32'(bus.mem_req), 1);
    check("hold rdy1", 32'(bus.st_ready), 0);
    bus.st_addr = 32'h0000_6004;
    bus.st_data = 32'h0BAD_BEEF;
    step();
    check("hold wdata", bus.mem_wdata, 32'hCAFE_F00D);
    check("hold addr",  bus.mem_addr, 32'h0000_6000);
    check("hold req2",  32'(bus.mem_req), 1);
    bus.mem_ack = 1'b1;
    if (bus.mem_req && bus.mem_ack) writes++;
    step();
    bus.mem_ack   = 1'b0;
    check("hold done", 32'(bus.st_done), 1);
    check("hold rdy3", 32'(bus.st_ready), 0);
    bus.st_funct3 = 3'b001;
    bus.st_addr   = 32'h0000_6002;
    bus.st_data   = 32'h0000_ABCD;
    step();
    check("hold idle req", 32'(bus.mem_req), 0);
    check("hold idle rdy", 32'(bus.st_ready), 1);
    check("hold writes",   32'(writes), 1);
    step();
    bus.st_valid = 1'b0;
    check("2nd req",   32'(bus.mem_req), 1);
    check("2nd be",    32'(bus.mem_be), 32'h0000_000C);
    check("2nd wdata", bus.mem_wdata, 32'hABCD_ABCD);
    check("2nd addr",  bus.mem_addr, 32'h0000_6000);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("2nd done", 32'(bus.st_done), 1);
    step();
    check("2nd rdy", 32'(bus.st_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/st_align.md
Name: st_align

Overview:
- Store-side counterpart of the immediate/load sign-zero extender in the single-cycle core.
- The extender widens narrow fields to 32 bits. This block narrows 32-bit rs2 data to byte/half/word for stores.
- Replicates store data onto the correct byte lanes, generates byte enables and flags misalignment.
- Drives a request/acknowledge handshake to data memory, sitting between the execute stage and the data memory port.

Parameters:
- ADDR_W, 32, width of byte address.
- TIMEOUT, 16, max REQ cycles without mem_ack before a timeout error; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- st_valid  input  1  store request from core.
- st_ready  output  1  block idle, can accept a request.
- st_funct3  input  3  000 = SB, 001 = SH, 010 = SW; all others illegal.
- st_addr  input  ADDR_W  byte address.
- st_data  input  32  rs2 store data.
- mem_req  output  1  memory write request.
- mem_addr  output  ADDR_W  word-aligned address, bits [1:0] = 00.
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables; bit i enables byte lane i.
- mem_ack  input  1  memory accepted the write.
- st_done  output  1  one-cycle pulse on successful completion.
- st_err  output  1  one-cycle pulse on error.
- st_err_code  output  2  01 = misaligned, 10 = timeout, 11 = illegal funct3, 00 = none.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-low on clk.
- On a clk edge with rst_n = 0:
  - state becomes IDLE;
  - mem_req, mem_addr, mem_wdata, mem_be, st_done, st_err and st_err_code become 0;
  - the timeout counter clears.
- st_ready = (state == IDLE), decoded from state, so it is 1 from the first edge after reset.
- States: IDLE, REQ, DONE, ERR.
- IDLE: accepts when st_valid = 1. Captures funct3, addr and data into registers.
  - funct3 not in {000, 001, 010}: go to ERR, code 11. Illegal funct3 takes priority over misalignment.
  - SH with addr[0] = 1, or SW with addr[1:0] != 00: go to ERR, code 01.
  - Otherwise go to REQ with mem_addr = {addr[ADDR_W-1:2], 2'b00} and the lane outputs below.
  - Lane rules:
    - SB: mem_wdata = {4{data[7:0]}}, mem_be = 4'b0001 << addr[1:0].
    - SH: mem_wdata = {2{data[15:0]}}, mem_be = addr[1] ? 4'b1100 : 4'b0011.
    - SW: mem_wdata = data, mem_be = 4'b1111.
- REQ:
  - mem_req = 1. mem_addr, mem_wdata and mem_be are held stable until exit.
  - mem_ack = 1: go to DONE. mem_ack is sampled in the same cycle, so a zero-wait ack completes in 1 REQ cycle.
  - The counter increments on each REQ cycle without ack.
  - If the counter reaches TIMEOUT - 1 and mem_ack = 0 in that cycle: go to ERR, code 10.
  - If ack and the timeout limit coincide, ack wins.
- DONE: st_done = 1 for exactly one cycle, mem_req = 0, counter clears, then IDLE.
- ERR: st_err = 1 for exactly one cycle, mem_req = 0, then IDLE. st_err_code holds its value until the next accepted request, where it clears to 00.
- Latency:
  - Accept edge N gives mem_req = 1 in cycle N+1.
  - mem_ack sampled at edge M gives st_done in cycle M+1 and st_ready = 1 in cycle M+2.
  - An error path gives st_err in the cycle after accept.
- mem_ack outside REQ is ignored. st_valid outside IDLE is ignored and not queued.
- Reset during REQ aborts the write: the next cycle has mem_req = 0, and no done or err pulse is issued.

Optional Feature:
- Macro: ST_TIMEOUT_EN.
- Defined: timeout counter and code 10 are implemented as above.
- Undefined:
  - no counter is instantiated;
  - REQ waits for mem_ack indefinitely;
  - code 10 is never produced;
  - TIMEOUT is unused.

Test Plan:
- SB, addr 0x1003, data 0xAABBCC5A; ack 3 cycles after mem_req -> mem_addr 0x1000, mem_be 1000, mem_wdata 0x5A5A5A5A, stable for 3 cycles; st_done pulse the cycle after ack.
- SH, addr 0x2002, data 0x1234BEEF; zero-wait ack -> mem_be 1100, mem_wdata 0xBEEFBEEF; 1 REQ cycle; st_ready back 2 cycles after ack.
- SW, addr 0x3001 -> no mem_req; st_err pulse with st_err_code 01 one cycle after accept. Repeat with funct3 011, addr 0x3001 -> code 11.
- ST_TIMEOUT_EN defined, TIMEOUT 16, SW addr 0x4000, mem_ack held 0 -> mem_req high exactly 16 cycles, then st_err with code 10; a late mem_ack afterwards is ignored.
- SW addr 0x5000, then rst_n = 0 for 1 cycle during the 2nd REQ cycle -> next cycle mem_req 0, st_ready 1, outputs 0, no st_done or st_err. A following SB to 0x5001 completes with mem_be 0010.
- st_valid held high through a REQ -> exactly one memory write; a second request is accepted only when st_ready returns to 1.
